// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed seven-segment scanner with tear-free frame-synchronous loading
module seven_seg_scan #(
    parameter int N_DIGITS       = 4,
    parameter int DIV            = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   din,
    input  logic [N_DIGITS-1:0]     dot_en,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic                    blank,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame
);

    localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    // Inactive output levels; XOR with these also applies the polarity inversion.
    localparam logic [7:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PS_W-1:0]         presc;
    logic [IDX_W-1:0]        idx;
    logic [4*N_DIGITS-1:0]   disp_hex;
    logic [N_DIGITS-1:0]     disp_dot;
    logic [4*N_DIGITS-1:0]   pend_hex;
    logic [N_DIGITS-1:0]     pend_dot;
    logic                    pend_flag;
    logic                    boundary;

    logic [3:0]              cur_hex;
    logic                    cur_dot;
    logic                    cur_blanked;
    logic                    zero_run;
    logic [N_DIGITS-1:0]     an_log;

    function automatic logic [6:0] seg_lut(input logic [3:0] h);
        case (h)
            4'h0: seg_lut = 7'h3F;
            4'h1: seg_lut = 7'h06;
            4'h2: seg_lut = 7'h5B;
            4'h3: seg_lut = 7'h4F;
            4'h4: seg_lut = 7'h66;
            4'h5: seg_lut = 7'h6D;
            4'h6: seg_lut = 7'h7D;
            4'h7: seg_lut = 7'h07;
            4'h8: seg_lut = 7'h7F;
            4'h9: seg_lut = 7'h6F;
            4'hA: seg_lut = 7'h77;
            4'hB: seg_lut = 7'h7C;
            4'hC: seg_lut = 7'h39;
            4'hD: seg_lut = 7'h5E;
            4'hE: seg_lut = 7'h79;
            default: seg_lut = 7'h71;
        endcase
    endfunction

    assign boundary = (presc == PS_W'(DIV - 1)) && (idx == IDX_W'(N_DIGITS - 1));

    // Prescaler and digit index; the index steps only on the prescaler wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PS_W'(DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            presc <= presc + PS_W'(1);
        end
    end

    // Loads park in the pending register; the display register only changes on a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_hex  <= '0;
            disp_dot  <= '0;
            pend_hex  <= '0;
            pend_dot  <= '0;
            pend_flag <= 1'b0;
        end else if (boundary) begin
            pend_flag <= 1'b0;
            if (load) begin
                disp_hex <= din;
                disp_dot <= dot_en;
            end else if (pend_flag) begin
                disp_hex <= pend_hex;
                disp_dot <= pend_dot;
            end
        end else if (load) begin
            pend_hex  <= din;
            pend_dot  <= dot_en;
            pend_flag <= 1'b1;
        end
    end

    // Select the scanned digit and decide leading-zero blanking from the top digit down.
    always_comb begin
        cur_hex     = 4'h0;
        cur_dot     = 1'b0;
        cur_blanked = 1'b0;
        zero_run    = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_hex[4*i +: 4] == 4'h0);
            if (int'(idx) == i) begin
                cur_hex     = disp_hex[4*i +: 4];
                cur_dot     = disp_dot[i];
                cur_blanked = lz_blank && (i != 0) && zero_run;
            end
        end
        an_log = N_DIGITS'(1) << idx;
    end

    // Registered outputs: one cycle behind the index, display register and mode inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg   <= SEG_OFF;
            an    <= AN_OFF;
            frame <= 1'b0;
        end else begin
            frame <= boundary;
            if (blank || cur_blanked) begin
                seg <= SEG_OFF;
                an  <= AN_OFF;
            end else begin
                seg <= {cur_dot, seg_lut(cur_hex)} ^ SEG_OFF;
                an  <= an_log ^ AN_OFF;
            end
        end
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, the number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter DIV, default 1000, the clocks per digit slot (legal >= 2).
REQ-003 The block SHALL have parameter SEG_ACTIVE_LOW, default 0, which inverts seg when 1.
REQ-004 The block SHALL have parameter AN_ACTIVE_LOW, default 0, which inverts an when 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port din, input, 4*N_DIGITS bits: hex digits, with digit i at din[4i+3:4i] and digit 0 least significant.
REQ-008 The block SHALL have port dot_en, input, N_DIGITS bits: the decimal point request for each digit.
REQ-009 The block SHALL have port load, input, 1 bit: capture din and dot_en when high.
REQ-010 The block SHALL have port lz_blank, input, 1 bit: leading-zero blanking enable.
REQ-011 The block SHALL have port blank, input, 1 bit: blanks the whole display when high.
REQ-012 The block SHALL have port seg, output, 8 bits: seg[7] is dp, seg[6:0] is segments g..a.
REQ-013 The block SHALL have port an, output, N_DIGITS bits: one-hot digit enables.
REQ-014 The block SHALL have port frame, output, 1 bit: one-cycle pulse after each complete scan.

Function
REQ-015 Prescaler SHALL count 0..DIV-1 and wrap; on its wrap cycle, digit index SHALL advance 0..N_DIGITS-1 and wrap.
REQ-016 Frame boundary SHALL be the cycle in which prescaler==DIV-1 and index==N_DIGITS-1.
REQ-017 load=1 SHALL capture din/dot_en into a pending register and set a pending flag; later loads before the boundary SHALL overwrite it (last wins).
REQ-018 At a frame boundary with the pending flag set, the display register SHALL take the pending value and the flag SHALL clear; the display register SHALL never change elsewhere (no mid-frame tearing).
REQ-019 load=1 on a boundary cycle SHALL transfer that cycle's din/dot_en directly to the display register and leave the flag clear.
REQ-020 Segment encoding (logical, 1=lit, g..a) SHALL be: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71; dp SHALL equal the display register's dot bit for that digit.
REQ-021 seg and an SHALL be registered; in each cycle they SHALL reflect the index, display register and mode inputs of the previous cycle (1-cycle latency).
REQ-022 Logical an SHALL be one-hot at the index, unless the digit is blanked, in which case an and seg SHALL both be all-inactive.
REQ-023 With lz_blank=1, digit i>0 SHALL be blanked iff it and every higher digit are zero; digit 0 SHALL never be blanked by lz_blank, and lz_blank SHALL ignore dot bits.
REQ-024 blank=1 SHALL drive seg and an all-inactive while the prescaler, index, load and frame logic continue unaffected.
REQ-025 Output polarity SHALL be applied last: seg is inverted iff SEG_ACTIVE_LOW=1, and an is inverted iff AN_ACTIVE_LOW=1.
REQ-026 frame SHALL be high exactly the one cycle after each boundary.

Reset
REQ-027 While rst=1, the prescaler, index, display register, pending register, pending flag and frame SHALL be 0, and seg/an SHALL be at their inactive levels (0x00 and 0 with default polarity).
REQ-028 rst asserted mid-operation SHALL discard any pending load and restart scanning at digit 0, prescaler 0.
REQ-029 In the first cycle after rst falls, outputs SHALL show digit 0 of the cleared display: seg=0x3F, an=0001 (N_DIGITS=4, default polarity).

Verification (N_DIGITS=4, DIV=4 unless stated)
REQ-030 Reset: rst=1 for 3 cycles -> seg=0x00, an=0000, frame=0; first cycle after release -> seg=0x3F, an=0001.
REQ-031 Free scan, no load -> an = 0001,0010,0100,1000, each held 4 cycles, repeating; frame pulses once every 16 cycles.
REQ-032 Tear-free load: din=16'h12AF, dot_en=0100, load pulsed mid-frame -> digits stay 0x3F until the boundary; next frame shows digit0 0x71, digit1 0x77, digit2 0xDB, digit3 0x06.
REQ-033 Load on the boundary cycle and last-wins: two loads (16'h1111, then 16'h2222) in one frame -> 0x5B on all digits from the next frame; load of 16'h3333 on a boundary cycle -> 0x4F from the very next frame.
REQ-034 Blanking: lz_blank=1, din=16'h0050 -> digits 3,2 have an=0000 and seg=0x00, digit1 seg=0x6D, digit0 seg=0x3F; din=0 -> only digit0 lights (0x3F); blank=1 -> an=0000 for a full frame while frame still pulses.
REQ-035 Polarity and reset mid-operation: SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1 -> reset outputs seg=0xFF, an=1111; digit 8 with dot -> seg=0x00; rst pulsed while a load is pending -> display remains all 0 (0xC0 active-low) after reset.
